// File: rtl/traffic_interval_timer.sv
// traffic_interval_timer
//
// Programmable interval timer for the traffic-light controller. The
// controller FSM picks a duration with `interval` and raises `start_timer`.
// This block counts that many prescaled "second" ticks and then returns a
// one-cycle `expired` pulse, which advances the controller to its next light
// phase. The three durations (base, extended, yellow) live in this block and
// can be rewritten through the `prog_sync` strobe.
//
// Parameters
//   CLK_DIV   clock cycles per timer tick (must be >= 2)
//   VAL_W     width of the stored durations, in ticks
//   DEF_BASE  reset value of the base duration
//   DEF_EXT   reset value of the extended duration
//   DEF_YEL   reset value of the yellow duration
//
// Ports
//   clk                  single clock, rising edge
//   g_reset              asynchronous active-high reset
//   start_timer          start request; only its 0->1 transition starts a count
//   interval[1:0]        00 base, 01 extended, 10 yellow, 11 zero duration
//   prog_sync            one-cycle strobe that writes time_value
//   time_param_selector  00 base, 01 extended, 10 yellow, 11 ignored
//   time_value           value written on prog_sync
//   expired              one-cycle pulse when the interval completes
//   busy                 high while a count is in progress

module traffic_interval_timer #(
  parameter int CLK_DIV  = 4,
  parameter int VAL_W    = 4,
  parameter int DEF_BASE = 6,
  parameter int DEF_EXT  = 3,
  parameter int DEF_YEL  = 2
) (
  input  logic             clk,
  input  logic             g_reset,
  input  logic             start_timer,
  input  logic [1:0]       interval,
  input  logic             prog_sync,
  input  logic [1:0]       time_param_selector,
  input  logic [VAL_W-1:0] time_value,
  output logic             expired,
  output logic             busy
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    FIRE  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               startPrev_q;
  logic [VAL_W-1:0]   baseVal_q, extVal_q, yelVal_q;

  logic               startPulse;
  logic [VAL_W-1:0]   selVal;
  logic [VAL_W-1:0]   effVal;

  // Edge detect: holding start_timer high must not retrigger. startPrev_q
  // resets low, so a start held high through reset fires at the first edge.
  assign startPulse = start_timer & ~startPrev_q;

  // Duration picked by the controller. Code 11 is the zero-length interval
  // and never reaches the counter, so its value here is irrelevant.
  always_comb begin
    selVal = '0;
    case (interval)
      2'b00:   selVal = baseVal_q;
      2'b01:   selVal = extVal_q;
      2'b10:   selVal = yelVal_q;
      default: selVal = '0;
    endcase
  end

  // A programmed 0 would otherwise underflow the counter; treat it as 1 tick.
  assign effVal = (selVal == '0) ? VAL_W'(1) : selVal;

  // Duration registers. The load path reads the current (old) value, so a
  // write in the same cycle as a start only affects later starts.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      baseVal_q <= VAL_W'(DEF_BASE);
      extVal_q  <= VAL_W'(DEF_EXT);
      yelVal_q  <= VAL_W'(DEF_YEL);
    end else if (prog_sync) begin
      case (time_param_selector)
        2'b00:   baseVal_q <= time_value;
        2'b01:   extVal_q  <= time_value;
        2'b10:   yelVal_q  <= time_value;
        default: ;
      endcase
    end
  end

  // State, counter and prescaler registers.
  always_ff @(posedge clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pre_q       <= '0;
      startPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      startPrev_q <= start_timer;
    end
  end

  // Next-state logic. A start edge wins over everything else, which is what
  // suppresses an expiry that would have landed in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;

    if (startPulse) begin
      if (interval == 2'b11) begin
        state_d = FIRE;
      end else begin
        state_d = COUNT;
        cnt_d   = effVal;
        pre_d   = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        COUNT: begin
          // Prescaler wrap is one tick; the count ends on the tick at cnt 1.
          if (pre_q == PRE_MAX) begin
            pre_d = '0;
            cnt_d = cnt_q - VAL_W'(1);
            if (cnt_q == VAL_W'(1)) begin
              state_d = FIRE;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
        FIRE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from the state register.
  assign busy    = (state_q == COUNT);
  assign expired = (state_q == FIRE);

endmodule

// File: tb/tb_traffic_interval_timer.sv
// tb_traffic_interval_timer
//
// Self-checking bench for traffic_interval_timer. The reference model keeps
// only the three programmed durations, the previous start_timer level and
// the absolute edge number at which the next expiry is due. busy is expected
// strictly before that edge and expired exactly at it. Directed scenarios
// also measure expiry latency against fixed cycle counts.

module tb_traffic_interval_timer;

  localparam int CLK_DIV = 4;
  localparam int VAL_W   = 4;

  logic             clk = 1'b0;
  logic             g_reset;
  logic             start_timer;
  logic [1:0]       interval;
  logic             prog_sync;
  logic [1:0]       time_param_selector;
  logic [VAL_W-1:0] time_value;
  logic             expired;
  logic             busy;

  traffic_interval_timer #(
    .CLK_DIV (CLK_DIV),
    .VAL_W   (VAL_W),
    .DEF_BASE(6),
    .DEF_EXT (3),
    .DEF_YEL (2)
  ) dut (
    .clk                (clk),
    .g_reset            (g_reset),
    .start_timer        (start_timer),
    .interval           (interval),
    .prog_sync          (prog_sync),
    .time_param_selector(time_param_selector),
    .time_value         (time_value),
    .expired            (expired),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int edgeNum   = 0;
  int fireEdge  = -1;
  int regVal[3];
  bit prevStart = 1'b0;

  // Observation bookkeeping for latency checks
  int lastExpiredEdge = -1;
  int expiredCount    = 0;
  int busyCount       = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeNum,
               observed, expected);
    end
  endtask

  task automatic resetModel();
    fireEdge  = -1;
    regVal    = '{6, 3, 2};
    prevStart = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge and check
  // both outputs half a cycle later.
  task automatic applyStimulus(input bit st, input logic [1:0] iv, input bit pr,
                               input logic [1:0] sel, input logic [VAL_W-1:0] val);
    int n;
    start_timer         = st;
    interval            = iv;
    prog_sync           = pr;
    time_param_selector = sel;
    time_value          = val;
    @(posedge clk);
    edgeNum++;
    if (st && !prevStart) begin
      if (iv == 2'b11) begin
        fireEdge = edgeNum;
      end else begin
        n = regVal[iv];
        if (n == 0) n = 1;
        fireEdge = edgeNum + n * CLK_DIV;
      end
    end
    prevStart = st;
    if (pr && sel != 2'b11) regVal[sel] = int'(val);
    @(negedge clk);
    checkOutput("busy", busy, edgeNum < fireEdge);
    checkOutput("expired", expired, edgeNum == fireEdge);
    if (expired === 1'b1) begin
      lastExpiredEdge = edgeNum;
      expiredCount++;
    end
    if (busy === 1'b1) busyCount++;
  endtask

  task automatic idleCycles(input int n, input bit st, input logic [1:0] iv);
    for (int i = 0; i < n; i++) applyStimulus(st, iv, 1'b0, 2'b00, '0);
  endtask

  // Assert reset between edges, check outputs clear at once, hold it across
  // one edge and release it on the falling edge.
  task automatic doReset();
    #2 g_reset = 1'b1;
    #1;
    checkOutput("rst_busy_now", busy, 0);
    checkOutput("rst_expired_now", expired, 0);
    resetModel();
    @(posedge clk);
    edgeNum++;
    @(negedge clk);
    checkOutput("rst_busy_hold", busy, 0);
    checkOutput("rst_expired_hold", expired, 0);
    g_reset = 1'b0;
  endtask

  task automatic clearObs();
    lastExpiredEdge = -1;
    expiredCount    = 0;
    busyCount       = 0;
  endtask

  int e0;
  int e1;

  initial begin
    g_reset             = 1'b1;
    start_timer         = 1'b0;
    interval            = 2'b00;
    prog_sync           = 1'b0;
    time_param_selector = 2'b00;
    time_value          = '0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_expired", expired, 0);
    g_reset = 1'b0;

    // Base duration: 6 ticks x 4 cycles
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(30, 1'b0, 2'b00);
    checkOutput("base_latency", lastExpiredEdge - e0, 24);
    checkOutput("base_pulses", expiredCount, 1);
    checkOutput("base_busy_cycles", busyCount, 24);

    // Program extended to 5, start with start_timer held high throughout
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b01, 4'd5);
    clearObs();
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(60, 1'b1, 2'b01);
    checkOutput("ext_latency", lastExpiredEdge - e0, 20);
    checkOutput("ext_hold_pulses", expiredCount, 1);
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, '0);

    // Zero interval: expiry right after the start edge, never busy
    clearObs();
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(5, 1'b0, 2'b11);
    checkOutput("zero_latency", lastExpiredEdge - e0, 0);
    checkOutput("zero_busy_cycles", busyCount, 0);

    // Yellow programmed to 0 behaves as 1 tick
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b10, 4'd0);
    clearObs();
    applyStimulus(1'b1, 2'b10, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(8, 1'b0, 2'b10);
    checkOutput("yel0_latency", lastExpiredEdge - e0, 4);

    // Restart 10 cycles into a base count
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(9, 1'b0, 2'b00);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e1 = edgeNum;
    checkOutput("restart_gap", e1 - e0, 10);
    idleCycles(30, 1'b0, 2'b00);
    checkOutput("restart_pulses", expiredCount, 1);
    checkOutput("restart_latency", lastExpiredEdge - e1, 24);

    // Program base = 9 while a base count runs
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    applyStimulus(1'b0, 2'b00, 1'b1, 2'b00, 4'd9);
    idleCycles(28, 1'b0, 2'b00);
    checkOutput("progrun_latency", lastExpiredEdge - e0, 24);
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(40, 1'b0, 2'b00);
    checkOutput("base9_latency", lastExpiredEdge - e0, 36);

    // Asynchronous reset 7 cycles into a base count
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    idleCycles(6, 1'b0, 2'b00);
    doReset();
    idleCycles(40, 1'b0, 2'b00);
    checkOutput("reset_abort_pulses", expiredCount, 0);
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(30, 1'b0, 2'b00);
    checkOutput("post_reset_latency", lastExpiredEdge - e0, 24);

    // Start held high through reset counts as a start at the first edge
    start_timer = 1'b1;
    doReset();
    clearObs();
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00, '0);
    e0 = edgeNum;
    idleCycles(30, 1'b1, 2'b00);
    checkOutput("held_reset_latency", lastExpiredEdge - e0, 24);
    applyStimulus(1'b0, 2'b00, 1'b0, 2'b00, '0);

    // Randomized traffic checked against the model
    begin
      bit st;
      st = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 24) == 0) st = ~st;
        if ($urandom_range(0, 499) == 0) begin
          start_timer = st;
          doReset();
        end
        applyStimulus(st, 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0),
                      2'($urandom_range(0, 3)),
                      VAL_W'($urandom_range(0, 15)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
